// File: rtl/cp0_exception_unit_pkg.sv
// Shared definitions for the CP0 exception unit: exception type codes,
// Cause.ExcCode values, CP0 register numbers, register reset values and
// write masks, the FSM state type and the prioritisation helpers.
package cp0_exception_unit_pkg;

  // Committed exception type codes driven on except_type
  localparam logic [31:0] EXC_TYPE_NOEXC = 32'h0000_0000;
  localparam logic [31:0] EXC_TYPE_INT   = 32'h0000_0001;
  localparam logic [31:0] EXC_TYPE_ADEL  = 32'h0000_0004;
  localparam logic [31:0] EXC_TYPE_ADES  = 32'h0000_0005;
  localparam logic [31:0] EXC_TYPE_SYS   = 32'h0000_0008;
  localparam logic [31:0] EXC_TYPE_BP    = 32'h0000_0009;
  localparam logic [31:0] EXC_TYPE_RI    = 32'h0000_000a;
  localparam logic [31:0] EXC_TYPE_OV    = 32'h0000_000c;
  localparam logic [31:0] EXC_TYPE_ERET  = 32'h0000_000e;

  // Cause.ExcCode values
  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_BP   = 5'h09;
  localparam logic [4:0] EXCCODE_RI   = 5'h0a;
  localparam logic [4:0] EXCCODE_OV   = 5'h0c;

  // CP0 register numbers
  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;

  // Status: BEV set out of reset; software may write IM[15:8], EXL[1], IE[0]
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } exc_state_e;

  // Highest-priority pending exception for the M-stage instruction
  function automatic logic [31:0] exc_prioritise(
    input logic int_req,
    input logic adel,
    input logic ri,
    input logic sys,
    input logic bp,
    input logic ades,
    input logic ov,
    input logic eret
  );
    if (int_req)   return EXC_TYPE_INT;
    else if (adel) return EXC_TYPE_ADEL;
    else if (ri)   return EXC_TYPE_RI;
    else if (sys)  return EXC_TYPE_SYS;
    else if (bp)   return EXC_TYPE_BP;
    else if (ades) return EXC_TYPE_ADES;
    else if (ov)   return EXC_TYPE_OV;
    else if (eret) return EXC_TYPE_ERET;
    else           return EXC_TYPE_NOEXC;
  endfunction

  function automatic logic [4:0] exc_code(input logic [31:0] exc_type);
    case (exc_type)
      EXC_TYPE_ADEL: return EXCCODE_ADEL;
      EXC_TYPE_ADES: return EXCCODE_ADES;
      EXC_TYPE_SYS:  return EXCCODE_SYS;
      EXC_TYPE_BP:   return EXCCODE_BP;
      EXC_TYPE_RI:   return EXCCODE_RI;
      EXC_TYPE_OV:   return EXCCODE_OV;
      default:       return EXCCODE_INT;
    endcase
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer.
//  clk, rst      : clock, async active-high reset
//  count_we      : write Count (restarts the divider)
//  compare_we    : write Compare (clears the timer interrupt)
//  wdata         : write data for either register
//  count_o       : current Count
//  compare_o     : current Compare
//  ti_o          : timer interrupt, set when Count steps onto Compare
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);
  import cp0_exception_unit_pkg::*;

  localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  // With COUNT_DIV=1 the divider sits at 0 and every clock is a tick
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic             ti_q, ti_d;
  logic             tick;
  logic [31:0]      count_inc;

  always_comb begin
    tick      = (div_q == DIV_LAST);
    count_inc = count_q + 32'd1;
    div_d     = div_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;

    if (count_we) begin
      count_d = wdata;
      div_d   = '0;
    end else if (tick) begin
      count_d = count_inc;
      div_d   = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (compare_we) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end else if (!count_we && tick && (count_inc == compare_q)) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_exception_unit.sv
// M-stage exception unit with the CP0 register file.
//  ext_int                  : hardware interrupt levels (top line ORed with timer)
//  ri..eret, pcerror        : exception flags for the M-stage instruction
//  is_in_delayslotM, pcM    : delay-slot flag and PC of the M-stage instruction
//  alu_outM                 : data address, source of BadVAddr for ADES/ADEL
//  stallM                   : M stage stalled; exceptions wait in PEND until it clears
//  cp0_we/waddr/wdata       : MTC0 write port
//  cp0_raddr/cp0_rdata      : MFC0 read port (combinational, write-forwarded)
//  except_type/flush_exception/pc_exception : registered commit outputs
//  cp0_status_o/cause_o/epc_o : current register values
module cp0_exception_unit #(
  parameter int unsigned N_HW_INT   = 6,
  parameter logic [31:0] EXC_VECTOR = 32'hbfc0_0380,
  parameter int unsigned COUNT_DIV  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_HW_INT-1:0] ext_int,
  input  logic                ri,
  input  logic                brek,
  input  logic                syscall,
  input  logic                overflow,
  input  logic                ades,
  input  logic                adel,
  input  logic                pcerror,
  input  logic                eret,
  input  logic                is_in_delayslotM,
  input  logic [31:0]         pcM,
  input  logic [31:0]         alu_outM,
  input  logic                stallM,
  input  logic                cp0_we,
  input  logic [4:0]          cp0_waddr,
  input  logic [31:0]         cp0_wdata,
  input  logic [4:0]          cp0_raddr,
  output logic [31:0]         cp0_rdata,
  output logic [31:0]         except_type,
  output logic                flush_exception,
  output logic [31:0]         pc_exception,
  output logic [31:0]         cp0_status_o,
  output logic [31:0]         cp0_cause_o,
  output logic [31:0]         cp0_epc_o
);
  import cp0_exception_unit_pkg::*;

  exc_state_e  state_q, state_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badv_q, badv_d;
  logic [31:0] pend_type_q, pend_type_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] pend_bad_q, pend_bad_d;
  logic        pend_bd_q, pend_bd_d;
  logic [31:0] except_type_q, except_type_d;
  logic        flush_q, flush_d;
  logic [31:0] pc_exc_q, pc_exc_d;

  logic [31:0] count, compare;
  logic        timer_ti;
  logic [5:0]  ip_hw;
  logic        int_req;
  logic [31:0] cur_type, cur_bad;
  logic        commit;
  logic [31:0] cm_type, cm_pc, cm_bad;
  logic        cm_bd;
  logic        count_we, compare_we;

  always_comb begin
    ip_hw                 = '0;
    ip_hw[N_HW_INT-1:0]   = ext_int;
    ip_hw[5]              = ip_hw[5] | timer_ti;
  end

  assign int_req  = status_q[0] & ~status_q[1] & (|(status_q[15:8] & cause_q[15:8]));
  assign cur_type = exc_prioritise(int_req, adel | pcerror, ri, syscall, brek, ades, overflow, eret);
  assign cur_bad  = pcerror ? pcM : alu_outM;

  // Commit selection: live flags in IDLE, the latched exception in PEND
  always_comb begin
    state_d     = state_q;
    pend_type_d = pend_type_q;
    pend_pc_d   = pend_pc_q;
    pend_bad_d  = pend_bad_q;
    pend_bd_d   = pend_bd_q;
    commit      = 1'b0;
    cm_type     = cur_type;
    cm_pc       = pcM;
    cm_bad      = cur_bad;
    cm_bd       = is_in_delayslotM;
    case (state_q)
      ST_IDLE: begin
        if (cur_type != EXC_TYPE_NOEXC) begin
          if (stallM) begin
            pend_type_d = cur_type;
            pend_pc_d   = pcM;
            pend_bad_d  = cur_bad;
            pend_bd_d   = is_in_delayslotM;
            state_d     = ST_PEND;
          end else begin
            commit = 1'b1;
          end
        end
      end
      ST_PEND: begin
        cm_type = pend_type_q;
        cm_pc   = pend_pc_q;
        cm_bad  = pend_bad_q;
        cm_bd   = pend_bd_q;
        if (!stallM) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register file updates; a commit takes precedence over a same-cycle MTC0
  always_comb begin
    status_d       = status_q;
    cause_d        = cause_q;
    epc_d          = epc_q;
    badv_d         = badv_q;
    cause_d[15:10] = ip_hw;
    if (commit) begin
      if (cm_type == EXC_TYPE_ERET) begin
        status_d[1] = 1'b0;
      end else begin
        if (!status_q[1]) begin
          epc_d       = cm_bd ? (cm_pc - 32'd4) : cm_pc;
          cause_d[31] = cm_bd;
        end
        cause_d[6:2] = exc_code(cm_type);
        status_d[1]  = 1'b1;
        if ((cm_type == EXC_TYPE_ADEL) || (cm_type == EXC_TYPE_ADES)) begin
          badv_d = cm_bad;
        end
      end
    end else if (cp0_we) begin
      case (cp0_waddr)
        CP0_REG_STATUS: status_d = (status_q & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
        CP0_REG_CAUSE:  cause_d[9:8] = cp0_wdata[9:8];
        CP0_REG_EPC:    epc_d = cp0_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    flush_d       = commit;
    except_type_d = commit ? cm_type : '0;
    pc_exc_d      = '0;
    if (commit) begin
      pc_exc_d = (cm_type == EXC_TYPE_ERET) ? epc_q : EXC_VECTOR;
    end
  end

  assign count_we   = cp0_we & ~commit & (cp0_waddr == CP0_REG_COUNT);
  assign compare_we = cp0_we & ~commit & (cp0_waddr == CP0_REG_COMPARE);

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (cp0_wdata),
    .count_o    (count),
    .compare_o  (compare),
    .ti_o       (timer_ti)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      status_q      <= STATUS_RESET;
      cause_q       <= '0;
      epc_q         <= '0;
      badv_q        <= '0;
      pend_type_q   <= '0;
      pend_pc_q     <= '0;
      pend_bad_q    <= '0;
      pend_bd_q     <= 1'b0;
      except_type_q <= '0;
      flush_q       <= 1'b0;
      pc_exc_q      <= '0;
    end else begin
      state_q       <= state_d;
      status_q      <= status_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      badv_q        <= badv_d;
      pend_type_q   <= pend_type_d;
      pend_pc_q     <= pend_pc_d;
      pend_bad_q    <= pend_bad_d;
      pend_bd_q     <= pend_bd_d;
      except_type_q <= except_type_d;
      flush_q       <= flush_d;
      pc_exc_q      <= pc_exc_d;
    end
  end

  always_comb begin
    case (cp0_raddr)
      CP0_REG_BADVADDR: cp0_rdata = badv_q;
      CP0_REG_COUNT:    cp0_rdata = count;
      CP0_REG_COMPARE:  cp0_rdata = compare;
      CP0_REG_STATUS:   cp0_rdata = status_q;
      CP0_REG_CAUSE:    cp0_rdata = cause_q;
      CP0_REG_EPC:      cp0_rdata = epc_q;
      default:          cp0_rdata = '0;
    endcase
    if (cp0_we && (cp0_raddr == cp0_waddr)) begin
      cp0_rdata = cp0_wdata;
    end
  end

  assign except_type     = except_type_q;
  assign flush_exception = flush_q;
  assign pc_exception    = pc_exc_q;
  assign cp0_status_o    = status_q;
  assign cp0_cause_o     = cause_q;
  assign cp0_epc_o       = epc_q;

endmodule

// File: tb/tb_cp0_exception_unit.sv
module tb_cp0_exception_unit;
  import cp0_exception_unit_pkg::*;

  localparam logic [31:0] VEC = 32'hbfc0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  ext_int;
  logic        ri, brek, syscall, overflow, ades, adel, pcerror, eret;
  logic        is_in_delayslotM;
  logic [31:0] pcM, alu_outM;
  logic        stallM;
  logic        cp0_we;
  logic [4:0]  cp0_waddr, cp0_raddr;
  logic [31:0] cp0_wdata, cp0_rdata;
  logic [31:0] except_type, pc_exception;
  logic        flush_exception;
  logic [31:0] cp0_status_o, cp0_cause_o, cp0_epc_o;

  typedef struct {
    logic [31:0] typ;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  cp0_exception_unit #(
    .N_HW_INT   (6),
    .EXC_VECTOR (VEC),
    .COUNT_DIV  (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ext_int          (ext_int),
    .ri               (ri),
    .brek             (brek),
    .syscall          (syscall),
    .overflow         (overflow),
    .ades             (ades),
    .adel             (adel),
    .pcerror          (pcerror),
    .eret             (eret),
    .is_in_delayslotM (is_in_delayslotM),
    .pcM              (pcM),
    .alu_outM         (alu_outM),
    .stallM           (stallM),
    .cp0_we           (cp0_we),
    .cp0_waddr        (cp0_waddr),
    .cp0_wdata        (cp0_wdata),
    .cp0_raddr        (cp0_raddr),
    .cp0_rdata        (cp0_rdata),
    .except_type      (except_type),
    .flush_exception  (flush_exception),
    .pc_exception     (pc_exception),
    .cp0_status_o     (cp0_status_o),
    .cp0_cause_o      (cp0_cause_o),
    .cp0_epc_o        (cp0_epc_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every flush must match the oldest expected commit
  always @(negedge clk) begin
    if (!rst && flush_exception) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_flush", {31'b0, flush_exception}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("except_type", except_type, e.typ);
        check_eq("pc_exception", pc_exception, e.pc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_raddr = a;
    #1;
    d = cp0_rdata;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cp0_we    = 1'b1;
    cp0_waddr = a;
    cp0_wdata = d;
    step();
    cp0_we    = 1'b0;
  endtask

  task automatic clear_flags();
    ri = 0; brek = 0; syscall = 0; overflow = 0;
    ades = 0; adel = 0; pcerror = 0; eret = 0;
    is_in_delayslotM = 0;
  endtask

  task automatic push_exp(input logic [31:0] t, input logic [31:0] p);
    exp_t e;
    e.typ = t;
    e.pc  = p;
    sb.push_back(e);
  endtask

  task automatic wait_sb_empty(input int unsigned max_cyc);
    int unsigned n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("sb_drain", sb.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1;
    ext_int = '0;
    clear_flags();
    pcM = '0; alu_outM = '0; stallM = 0;
    cp0_we = 0; cp0_waddr = '0; cp0_wdata = '0; cp0_raddr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    rd(CP0_REG_STATUS, v);  check_eq("reset_status", v, 32'h0040_0000);
    rd(CP0_REG_COUNT, v);   check_eq("reset_count", v, 32'h0);
    check_eq("reset_flush", {31'b0, flush_exception}, 32'd0);

    // Syscall, no stall
    pcM = 32'hbfc0_1000; syscall = 1;
    push_exp(EXC_TYPE_SYS, VEC);
    step();
    clear_flags();
    wait_sb_empty(4);
    step();
    check_eq("sys_flush_pulse", {31'b0, flush_exception}, 32'd0);
    rd(CP0_REG_EPC, v);     check_eq("sys_epc", v, 32'hbfc0_1000);
    rd(CP0_REG_CAUSE, v);   check_eq("sys_exccode", {27'b0, v[6:2]}, 32'h8);
    rd(CP0_REG_STATUS, v);  check_eq("sys_exl", {31'b0, v[1]}, 32'd1);

    // ADEL held across a 3-cycle stall; a later flag during PEND is ignored
    wr(CP0_REG_STATUS, 32'h0);
    pcM = 32'h300; alu_outM = 32'h1234_5679; adel = 1; stallM = 1;
    push_exp(EXC_TYPE_ADEL, VEC);
    step();
    clear_flags(); syscall = 1;
    check_eq("adel_stall1", {31'b0, flush_exception}, 32'd0);
    step();
    syscall = 0;
    check_eq("adel_stall2", {31'b0, flush_exception}, 32'd0);
    step();
    check_eq("adel_stall3", {31'b0, flush_exception}, 32'd0);
    stallM = 0;
    wait_sb_empty(4);
    rd(CP0_REG_BADVADDR, v); check_eq("adel_badvaddr", v, 32'h1234_5679);
    rd(CP0_REG_CAUSE, v);    check_eq("adel_exccode", {27'b0, v[6:2]}, 32'h4);

    // RI beats OV, instruction in delay slot
    wr(CP0_REG_STATUS, 32'h0);
    pcM = 32'h100; ri = 1; overflow = 1; is_in_delayslotM = 1;
    push_exp(EXC_TYPE_RI, VEC);
    step();
    clear_flags();
    wait_sb_empty(4);
    rd(CP0_REG_EPC, v);    check_eq("ri_epc", v, 32'h0000_00fc);
    rd(CP0_REG_CAUSE, v);  check_eq("ri_bd", {31'b0, v[31]}, 32'd1);
    check_eq("ri_exccode", {27'b0, v[6:2]}, 32'ha);

    // Count wrap onto Compare=0 sets the timer interrupt (IE=0, so no flush)
    wr(CP0_REG_STATUS, 32'h0);
    wr(CP0_REG_COUNT, 32'hffff_ffff);
    step();
    step();
    rd(CP0_REG_COUNT, v);  check_eq("count_wrap", v, 32'h0);
    step();
    rd(CP0_REG_CAUSE, v);  check_eq("wrap_ip7", {31'b0, v[15]}, 32'd1);

    // Same-cycle write forwarding and unimplemented register
    cp0_we = 1; cp0_waddr = CP0_REG_EPC; cp0_wdata = 32'hdead_beef;
    rd(CP0_REG_EPC, v);    check_eq("rd_forward", v, 32'hdead_beef);
    step();
    cp0_we = 0;
    rd(CP0_REG_EPC, v);    check_eq("epc_written", v, 32'hdead_beef);
    rd(5'd3, v);           check_eq("rd_unimpl", v, 32'h0);

    // Reset while an exception is pending drops it silently
    adel = 1; alu_outM = 32'h55; stallM = 1;
    step();
    clear_flags();
    rst = 1'b1;
    step();
    rst = 1'b0; stallM = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_pend_noflush", {31'b0, flush_exception}, 32'd0);
    end
    rd(CP0_REG_EPC, v);    check_eq("rst_pend_epc", v, 32'h0);
    rd(CP0_REG_STATUS, v); check_eq("rst_pend_status", v, 32'h0040_0000);

    // Timer interrupt: Compare=5, Count restarted at 0
    pcM = 32'h400;
    wr(CP0_REG_STATUS, 32'h0000_8001);
    wr(CP0_REG_COMPARE, 32'd5);
    push_exp(EXC_TYPE_INT, VEC);
    wr(CP0_REG_COUNT, 32'd0);
    wait_sb_empty(40);
    rd(CP0_REG_EPC, v);    check_eq("int_epc", v, 32'h400);
    rd(CP0_REG_CAUSE, v);  check_eq("int_exccode", {27'b0, v[6:2]}, 32'h0);
    check_eq("int_ip7", {31'b0, v[15]}, 32'd1);
    rd(CP0_REG_STATUS, v); check_eq("int_status", v, 32'h0040_8003);
    wr(CP0_REG_COMPARE, 32'd1000);
    step();
    step();
    rd(CP0_REG_CAUSE, v);  check_eq("ip7_cleared", {31'b0, v[15]}, 32'd0);

    // ERET redirects to EPC; a same-cycle MTC0 to EPC is dropped
    wr(CP0_REG_EPC, 32'h200);
    push_exp(EXC_TYPE_ERET, 32'h200);
    eret = 1;
    cp0_we = 1; cp0_waddr = CP0_REG_EPC; cp0_wdata = 32'h999;
    step();
    clear_flags();
    cp0_we = 0;
    wait_sb_empty(4);
    rd(CP0_REG_EPC, v);    check_eq("eret_epc", v, 32'h200);
    rd(CP0_REG_STATUS, v); check_eq("eret_exl", {31'b0, v[1]}, 32'd0);

    repeat (4) step();
    check_eq("sb_final", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
